// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a big-endian byte stream into
// 32-bit words and writes them at consecutive word addresses from BASE_ADDR.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h00400000,
   parameter int          DEPTH     = 18
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] num_words,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        wr_en,
   output logic [31:0] wr_address,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   state_t      state;
   logic [15:0] count;
   logic [15:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] shift;
   logic        byte_take;

   assign byte_take = in_valid && in_ready;
   assign cpu_hold  = busy;

   // Every output is a register; the byte that completes a word goes straight
   // into wr_data so the write strobe appears in the cycle after that byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         count      <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         shift      <= '0;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_address <= BASE_ADDR;
         wr_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (num_words == 16'd0 || num_words > DEPTH_W) begin
                     error <= 1'b1;
                  end else begin
                     error    <= 1'b0;
                     count    <= num_words;
                     word_idx <= '0;
                     byte_cnt <= '0;
                     busy     <= 1'b1;
                     in_ready <= 1'b1;
                     state    <= S_COLLECT;
                  end
               end
            end
            S_COLLECT: begin
               if (byte_take) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  shift    <= {shift[15:0], in_data};
                  if (byte_cnt == 2'd3) begin
                     wr_data    <= {shift, in_data};
                     wr_address <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                     wr_en      <= 1'b1;
                     in_ready   <= 1'b0;
                     state      <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (word_idx == count - 16'd1) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  word_idx <= word_idx + 16'd1;
                  byte_cnt <= '0;
                  in_ready <= 1'b1;
                  state    <= S_COLLECT;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
